// File: rtl/univ_shiftreg.sv
// Universal N-bit shift register: hold, logical/arithmetic shifts, rotates,
// parallel load and clear, plus a saturating count of shifts since the last
// reset, load or clear.
module univ_shiftreg #(
  parameter int            N         = 8,
  parameter logic [N-1:0]  RESET_VAL = '0,
  localparam int           CW        = $clog2(N + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [2:0]    MODE,
  input  logic          SIN_L,
  input  logic          SIN_R,
  input  logic [N-1:0]  D,
  output logic [N-1:0]  Q,
  output logic          SOUT_L,
  output logic          SOUT_R,
  output logic [CW-1:0] CNT,
  output logic          DONE
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shift;

  // Next-state selection for the data register and the shift counter.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    q_d   = q_q;
    cnt_d = cnt_q;
    shift = 1'b0;
    if (EN) begin
      case (mode_e'(MODE))
        MODE_HOLD: ;
        MODE_SHL: begin q_d = {q_q[N-2:0], SIN_L};    shift = 1'b1; end
        MODE_SHR: begin q_d = {SIN_R, q_q[N-1:1]};    shift = 1'b1; end
        MODE_ROL: begin q_d = {q_q[N-2:0], q_q[N-1]}; shift = 1'b1; end
        MODE_ROR: begin q_d = {q_q[0], q_q[N-1:1]};   shift = 1'b1; end
        MODE_ASR: begin q_d = {q_q[N-1], q_q[N-1:1]}; shift = 1'b1; end
        MODE_LOAD: begin q_d = D;  cnt_d = '0; end
        // Clear goes to zero, deliberately not to RESET_VAL.
        MODE_CLR:  begin q_d = '0; cnt_d = '0; end
        default: ;
      endcase
    end
    // Counter saturates at N so DONE stays asserted under further shifting.
    if (shift && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // State registers; synchronous reset overrides enable and mode.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q      = q_q;
  assign SOUT_L = q_q[N-1];
  assign SOUT_R = q_q[0];
  assign CNT    = cnt_q;
  assign DONE   = (cnt_q == CNT_MAX);

endmodule
